// File: rtl/input_buffer_ctrl.sv
// Read sequencer for the 3-channel activation input buffer: issues one window
// read at a time, gated on channel occupancy and PE readiness, and checks the returned valids.
module ibc_ch_ready #(
    parameter int FF_ADDR_WIDTH = 3,
    parameter int NUM_RDATA     = 3
) (
    input  logic [FF_ADDR_WIDTH-1:0] cnt_i,
    output logic                     rdy_o
);
    // Compare one bit wider so a NUM_RDATA at the top of the counter range still works.
    localparam logic [FF_ADDR_WIDTH:0] RD_MIN = NUM_RDATA;

    assign rdy_o = ({1'b0, cnt_i} >= RD_MIN);
endmodule

module input_buffer_ctrl #(
    parameter int FF_ADDR_WIDTH = 3,
    parameter int NUM_RDATA     = 3,
    parameter int CNT_WIDTH     = 8,
    parameter int VAL_TIMEOUT   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [CNT_WIDTH-1:0]     i_num_req,
    input  logic [FF_ADDR_WIDTH-1:0] i_data_counter_ch0,
    input  logic [FF_ADDR_WIDTH-1:0] i_data_counter_ch1,
    input  logic [FF_ADDR_WIDTH-1:0] i_data_counter_ch2,
    input  logic                     i_data_val_ch0,
    input  logic                     i_data_val_ch1,
    input  logic                     i_data_val_ch2,
    input  logic                     i_pe_ready,
    output logic                     o_data_req,
    output logic [CNT_WIDTH-1:0]     o_req_idx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);
    localparam int NUM_CH = 3;
    localparam int TMO_W  = $clog2(VAL_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(VAL_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT_VAL, DONE} state_t;

    state_t                              state_q;
    logic [CNT_WIDTH-1:0]                num_q;
    logic [CNT_WIDTH-1:0]                idx_q;
    logic [TMO_W-1:0]                    tmo_q;
    logic                                req_q, busy_q, done_q, err_q;

    logic [NUM_CH-1:0][FF_ADDR_WIDTH-1:0] ch_cnt;
    logic [NUM_CH-1:0]                   ch_rdy;
    logic [NUM_CH-1:0]                   ch_val;
    logic [CNT_WIDTH-1:0]                idx_d;
    logic                                issue_ok;

    assign ch_cnt   = {i_data_counter_ch2, i_data_counter_ch1, i_data_counter_ch0};
    assign ch_val   = {i_data_val_ch2, i_data_val_ch1, i_data_val_ch0};
    assign idx_d    = idx_q + CNT_WIDTH'(1);
    assign issue_ok = (&ch_rdy) && i_pe_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ibc_ch_ready #(
            .FF_ADDR_WIDTH (FF_ADDR_WIDTH),
            .NUM_RDATA     (NUM_RDATA)
        ) u_rdy (
            .cnt_i (ch_cnt[c]),
            .rdy_o (ch_rdy[c])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        err_q <= 1'b0;
                        if (i_num_req != '0) begin
                            num_q   <= i_num_req;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= CHECK;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                CHECK: begin
                    if (issue_ok) begin
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    tmo_q   <= '0;
                    state_q <= WAIT_VAL;
                end
                WAIT_VAL: begin
                    // A partial valid still consumes the read; it only flags the error.
                    if (|ch_val) begin
                        if (!(&ch_val))
                            err_q <= 1'b1;
                        idx_q <= idx_d;
                        if (idx_d == num_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CHECK;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_data_req = req_q;
    assign o_req_idx  = idx_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Scoreboard bench for input_buffer_ctrl: expected request indices are queued at
// job start and popped whenever the DUT pulses o_data_req.
module tb_input_buffer_ctrl;
    localparam int FW = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_num_req = '0;
    logic [FW-1:0] cnt0 = 3'd6, cnt1 = 3'd6, cnt2 = 3'd6;
    logic          v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic          pe = 1'b1;
    logic          o_data_req, o_busy, o_done, o_err;
    logic [CW-1:0] o_req_idx;

    input_buffer_ctrl #(
        .FF_ADDR_WIDTH (FW), .NUM_RDATA (3), .CNT_WIDTH (CW), .VAL_TIMEOUT (4)
    ) dut (
        .clk (clk), .rst (rst), .i_start (i_start), .i_num_req (i_num_req),
        .i_data_counter_ch0 (cnt0), .i_data_counter_ch1 (cnt1), .i_data_counter_ch2 (cnt2),
        .i_data_val_ch0 (v0), .i_data_val_ch1 (v1), .i_data_val_ch2 (v2),
        .i_pe_ready (pe), .o_data_req (o_data_req), .o_req_idx (o_req_idx),
        .o_busy (o_busy), .o_done (o_done), .o_err (o_err)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    int exp_q[$];
    int req_cyc[$];
    int req_cnt = 0;
    int e_idx;
    int val_mode = 0;   // 0: buffer answers on all channels, 1: buffer never answers
    int mis_read = -1;  // response number answered on ch0/ch2 only
    int resp_n = 0;
    logic req_seen = 1'b0;

    // Scoreboard: every request must match the next queued index.
    always @(negedge clk) begin
        if (rst && o_data_req === 1'b1) begin
            req_cnt++;
            req_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_req o_req_idx=%0d, no request expected", o_req_idx);
            end else begin
                e_idx = exp_q.pop_front();
                if (o_req_idx !== CW'(e_idx)) begin
                    failures++;
                    $display("FAIL req_idx got=%0d exp=%0d", o_req_idx, e_idx);
                end
            end
        end
    end

    // One clock; the buffer model answers the cycle after a request.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (req_seen) begin
            if (val_mode == 1)         {v0, v1, v2} = 3'b000;
            else if (resp_n == mis_read) {v0, v1, v2} = 3'b101;
            else                       {v0, v1, v2} = 3'b111;
            resp_n++;
        end else begin
            {v0, v1, v2} = 3'b000;
        end
        req_seen = o_data_req;
    endtask

    task automatic start_job(input int n);
        i_start   = 1'b1;
        i_num_req = CW'(n);
        tick();
        i_start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (o_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done_timeout o_done=%b exp=1 within %0d cycles", nm, o_done, budget);
        end
    endtask

    task automatic wait_req(input int budget, input string nm);
        int n = 0;
        while (o_data_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (o_data_req !== 1'b1) begin
            failures++;
            $display("FAIL %s_req_timeout o_data_req=%b exp=1 within %0d cycles", nm, o_data_req, budget);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks += 5;
        if (o_data_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", o_data_req); end
        if (o_req_idx !== '0)    begin failures++; $display("FAIL rst_idx got=%0d exp=0", o_req_idx); end
        if (o_busy !== 1'b0)     begin failures++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        if (o_done !== 1'b0)     begin failures++; $display("FAIL rst_done got=%b exp=0", o_done); end
        if (o_err !== 1'b0)      begin failures++; $display("FAIL rst_err got=%b exp=0", o_err); end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        req_cyc.delete();
        resp_n = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        start_job(4);
        checks++;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL norm_busy got=%b exp=1", o_busy); end
        wait_done(60, "norm");
        checks += 4;
        if (o_err !== 1'b0)    begin failures++; $display("FAIL norm_err got=%b exp=0", o_err); end
        if (o_busy !== 1'b0)   begin failures++; $display("FAIL norm_busy_at_done got=%b exp=0", o_busy); end
        if (o_req_idx !== 8'd4) begin failures++; $display("FAIL norm_idx_end got=%0d exp=4", o_req_idx); end
        if (req_cyc.size() != 4) begin failures++; $display("FAIL norm_req_count got=%0d exp=4", req_cyc.size()); end
        for (int i = 1; i < 4 && i < req_cyc.size(); i++) begin
            checks++;
            if (req_cyc[i] - req_cyc[i-1] != 3) begin
                failures++;
                $display("FAIL norm_gap%0d got=%0d exp=3", i, req_cyc[i] - req_cyc[i-1]);
            end
        end
        // Start during DONE must be dropped.
        start_job(2);
        checks += 2;
        if (o_done !== 1'b0) begin failures++; $display("FAIL norm_single_done got=%b exp=0", o_done); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL norm_start_in_done busy got=%b exp=0", o_busy); end
        repeat (6) tick();
    endtask

    task automatic test_starve();
        int c0;
        cnt1 = 3'd2;
        exp_q.push_back(0);
        start_job(1);
        c0 = req_cnt;
        repeat (10) tick();
        checks++;
        if (req_cnt != c0) begin failures++; $display("FAIL starve_ch1_req got=%0d exp=0", req_cnt - c0); end
        cnt1 = 3'd3;
        checks++;
        if (o_data_req !== 1'b0) begin failures++; $display("FAIL starve_ch1_early got=%b exp=0", o_data_req); end
        tick();
        checks++;
        if (o_data_req !== 1'b1) begin failures++; $display("FAIL starve_ch1_release got=%b exp=1", o_data_req); end
        wait_done(20, "starve_ch1");
        cnt1 = 3'd6;
        tick();

        pe = 1'b0;
        exp_q.push_back(0);
        start_job(1);
        c0 = req_cnt;
        repeat (5) tick();
        start_job(5);
        repeat (5) tick();
        checks += 2;
        if (req_cnt != c0) begin failures++; $display("FAIL starve_pe_req got=%0d exp=0", req_cnt - c0); end
        if (o_busy !== 1'b1) begin failures++; $display("FAIL starve_pe_busy got=%b exp=1", o_busy); end
        pe = 1'b1;
        tick();
        checks++;
        if (o_data_req !== 1'b1) begin failures++; $display("FAIL starve_pe_release got=%b exp=1", o_data_req); end
        wait_done(20, "starve_pe");
        checks += 2;
        if (req_cnt - c0 != 1) begin failures++; $display("FAIL busy_start_reqs got=%0d exp=1", req_cnt - c0); end
        if (o_req_idx !== 8'd1) begin failures++; $display("FAIL busy_start_idx got=%0d exp=1", o_req_idx); end
        tick();
    endtask

    task automatic test_misaligned();
        resp_n = 0;
        mis_read = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back(i);
        start_job(3);
        wait_done(40, "mis");
        checks += 2;
        if (o_err !== 1'b1)     begin failures++; $display("FAIL mis_err got=%b exp=1", o_err); end
        if (o_req_idx !== 8'd3) begin failures++; $display("FAIL mis_idx got=%0d exp=3", o_req_idx); end
        tick();
        checks++;
        if (o_err !== 1'b1) begin failures++; $display("FAIL mis_err_sticky got=%b exp=1", o_err); end
        mis_read = -1;
        start_job(0);
        checks += 3;
        if (o_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", o_done); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", o_busy); end
        if (o_err !== 1'b0)  begin failures++; $display("FAIL zero_err_clear got=%b exp=0", o_err); end
        tick();
        checks++;
        if (o_done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", o_done); end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        logic early = 1'b0;
        val_mode = 1;
        exp_q.push_back(0);
        start_job(2);
        wait_req(20, "tmo");
        tick();
        repeat (3) begin
            tick();
            early = early | o_done;
        end
        tick();
        checks += 5;
        if (early !== 1'b0)     begin failures++; $display("FAIL tmo_early_done got=%b exp=0", early); end
        if (o_done !== 1'b1)    begin failures++; $display("FAIL tmo_done got=%b exp=1", o_done); end
        if (o_err !== 1'b1)     begin failures++; $display("FAIL tmo_err got=%b exp=1", o_err); end
        if (o_req_idx !== 8'd0) begin failures++; $display("FAIL tmo_idx got=%0d exp=0", o_req_idx); end
        if (o_busy !== 1'b0)    begin failures++; $display("FAIL tmo_busy got=%b exp=0", o_busy); end
        val_mode = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        resp_n = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back(i);
        start_job(3);
        wait_req(20, "rstmid");
        tick();
        rst = 1'b0;
        #1;
        checks += 3;
        if (o_busy !== 1'b0)     begin failures++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
        if ({o_data_req, o_done, o_err} !== 3'b000) begin
            failures++; $display("FAIL rstmid_flags got=%b exp=000", {o_data_req, o_done, o_err});
        end
        if (o_req_idx !== '0) begin failures++; $display("FAIL rstmid_idx got=%0d exp=0", o_req_idx); end
        exp_q.delete();
        req_seen = 1'b0;
        {v0, v1, v2} = 3'b000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) exp_q.push_back(i);
        start_job(2);
        wait_done(40, "rstmid_rerun");
        checks += 3;
        if (o_req_idx !== 8'd2) begin failures++; $display("FAIL rstmid_rerun_idx got=%0d exp=2", o_req_idx); end
        if (o_err !== 1'b0)     begin failures++; $display("FAIL rstmid_rerun_err got=%b exp=0", o_err); end
        if (exp_q.size() != 0)  begin failures++; $display("FAIL rstmid_pending got=%0d exp=0", exp_q.size()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_starve();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
